tile_map_writer: RTL
====================

Name: tile_map_writer

Overview:
Write-side companion to the level tile map. It fills the tile RAM from the level ROM when a level is loaded (row-major, 300 tiles). During gameplay it applies single-tile edits such as broken blocks or collected items, addressed by pixel coordinate. It owns the only write port of the tile RAM; display and collision keep read-only access.

Parameters:
ROW_MAX, 14, last tile row index (15 rows)
COL_MAX, 19, last tile column index (20 columns)
LEFT, 144, first visible pixel column (h back-porch offset)
TOP, 35, first visible pixel row (v back-porch offset)
TILE_W, 3, tile code width
LVL_W, 2, level-select width (up to 4 levels)
ROM_AW, 11, level ROM address width (4 × 300 = 1200 entries)

Ports:
clk  in  1  system pixel-domain clock
rst_n  in  1  asynchronous active-low reset
load_req  in  1  single-cycle pulse: start loading level load_lvl
load_lvl  in  LVL_W  level index, sampled with load_req
rom_addr  out  ROM_AW  level ROM address; ROM data is valid 1 cycle later
rom_data  in  TILE_W  level ROM read data
edit_valid  in  1  edit request valid
edit_ready  out  1  edit request accepted when valid && ready
edit_x  in  10  edit pixel x
edit_y  in  10  edit pixel y
edit_tile  in  TILE_W  new tile code
edit_err  out  1  1-cycle pulse: accepted edit was out of range and dropped
wr_en  out  1  tile RAM write strobe
wr_row  out  4  tile RAM row
wr_col  out  5  tile RAM column
wr_data  out  TILE_W  tile RAM write data
busy  out  1  load in progress
load_done  out  1  1-cycle pulse after the final load write

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including rom_addr, wr_*, busy, load_done and edit_err. Counters clear.
- Reset mid-load: the load is abandoned and RAM contents written so far stay as they are. No load_done is issued.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - edit_ready = !load_req (combinational). A simultaneous load_req wins, and that edit is not accepted.
  - load_req → LOAD; rom_addr ← load_lvl×300; row and col counters ← 0.
- LOAD:
  - Each cycle rom_addr increments by 1, and col advances, wrapping at COL_MAX to 0 with row+1.
  - Row/col are delayed one stage to align with rom_data.
  - wr_en=1 with the delayed row/col and wr_data=rom_data.
  - Issuing address offset 299 (row 14, col 19) → DRAIN.
- DRAIN: performs the final write (row 14, col 19) → DONE.
- DONE: load_done=1 for one cycle; busy drops in the same cycle → IDLE.
- Load timing:
  - busy is high from the cycle after load_req through DRAIN.
  - The first wr_en comes 2 cycles after the load_req sample edge.
  - Exactly 300 consecutive wr_en cycles, in row-major order.
- load_req outside IDLE is ignored. edit_ready=0 whenever the state is not IDLE.
- Edit path (accepted in IDLE):
  - Registered, 1-cycle latency.
  - dx = edit_x − LEFT and dy = edit_y − TOP, as unsigned 10-bit values (underflow wraps large).
  - col = dx>>5, row = dy>>5.
  - Valid iff row ≤ ROW_MAX and col ≤ COL_MAX.
  - Valid edit → next cycle wr_en=1 with that row/col and edit_tile.
  - Invalid edit → next cycle edit_err=1 and wr_en=0.
- Back-to-back edits are accepted every cycle (1 per cycle).
- An edit accepted in the same cycle before load_req still completes its write. That write precedes the first load write, so there is no overlap.
- wr_en is never asserted with row > ROW_MAX or col > COL_MAX.

Decomposition:
- Shared package: ROW_MAX, COL_MAX, LEFT, TOP, TILES_PER_LVL=300, tile-code constants (EMPTY, SOLID, …, OOB=3), FSM state encoding.
- Sub-module pix_to_tile: pixel → row/col/valid. Reused by the read side to replace set_ptr, so both directions share one mapping.

Test Plan:
- load_req, load_lvl=1 → rom_addr walks 300..599; 300 writes from (0,0) to (14,19) in row-major order. wr_data matches the ROM model. First write 2 cycles after load_req. load_done fires exactly 1 cycle after the last write. busy spans the whole load.
- Edit x=245, y=99, tile=5 → the next cycle has wr_en with row 2, col 3, data 5, and edit_err=0.
- Boundaries: x=783, y=514 → writes (14,19). x=784 → edit_err pulse with no wr_en. x=100 (underflow) → edit_err.
- load_req and edit_valid in the same cycle → edit_ready=0 that cycle; the load proceeds; the edit is held and accepted in the first IDLE cycle after load_done.
- load_req asserted during LOAD → ignored; the address sequence and write count (300) are unchanged.
- rst_n low after the 150th load write → all outputs 0 immediately with no load_done. A fresh load_req then completes a full 300-write load.

Source files
------------

// File: rtl/tile_map_writer_pkg.sv
// rtl/tile_map_writer_pkg.sv - shared constants, tile codes and FSM encoding for the tile map writer
package tile_map_writer_pkg;

    localparam int ROW_MAX       = 14;
    localparam int COL_MAX       = 19;
    localparam int LEFT          = 144;
    localparam int TOP           = 35;
    localparam int TILE_W        = 3;
    localparam int LVL_W         = 2;
    localparam int ROM_AW        = 11;
    localparam int TILES_PER_LVL = 300;

    localparam logic [TILE_W-1:0] TILE_EMPTY = 3'd0;
    localparam logic [TILE_W-1:0] TILE_SOLID = 3'd1;
    localparam logic [TILE_W-1:0] TILE_BRICK = 3'd2;
    localparam logic [TILE_W-1:0] TILE_OOB   = 3'd3;
    localparam logic [TILE_W-1:0] TILE_COIN  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [ROM_AW-1:0] lvl_base(input logic [LVL_W-1:0] lvl);
        return ROM_AW'(lvl) * ROM_AW'(TILES_PER_LVL);
    endfunction

endpackage

// File: rtl/tile_map_writer_pix_to_tile.sv
// rtl/tile_map_writer_pix_to_tile.sv - pixel coordinate to tile row/col mapping, shared by read and write sides
module pix_to_tile
    import tile_map_writer_pkg::*;
(
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    output logic [3:0] row_o,
    output logic [4:0] col_o,
    output logic       valid_o
);

    logic [9:0] dx;
    logic [9:0] dy;
    logic [4:0] row_full;

    // Left/above the visible area wraps to a large value and fails the range check.
    assign dx       = x_i - 10'(LEFT);
    assign dy       = y_i - 10'(TOP);
    assign col_o    = dx[9:5];
    assign row_full = dy[9:5];
    assign row_o    = row_full[3:0];
    assign valid_o  = (row_full <= 5'(ROW_MAX)) && (col_o <= 5'(COL_MAX));

endmodule

// File: rtl/tile_map_writer.sv
// rtl/tile_map_writer.sv - sole writer of the tile RAM: level fill from ROM and single-tile gameplay edits
module tile_map_writer
    import tile_map_writer_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_req_i,
    input  logic [LVL_W-1:0]  load_lvl_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [TILE_W-1:0] rom_data_i,
    input  logic              edit_valid_i,
    output logic              edit_ready_o,
    input  logic [9:0]        edit_x_i,
    input  logic [9:0]        edit_y_i,
    input  logic [TILE_W-1:0] edit_tile_i,
    output logic              edit_err_o,
    output logic              wr_en_o,
    output logic [3:0]        wr_row_o,
    output logic [4:0]        wr_col_o,
    output logic [TILE_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              load_done_o
);

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [3:0]        row_q, row_d;
    logic [4:0]        col_q, col_d;

    logic              ld_vld_q;
    logic [3:0]        ld_row_q;
    logic [4:0]        ld_col_q;

    logic              ed_vld_q;
    logic              ed_err_q;
    logic [3:0]        ed_row_q;
    logic [4:0]        ed_col_q;
    logic [TILE_W-1:0] ed_tile_q;

    logic [3:0]        pt_row;
    logic [4:0]        pt_col;
    logic              pt_valid;
    logic              edit_accept;

    pix_to_tile u_pix_to_tile (
        .x_i     (edit_x_i),
        .y_i     (edit_y_i),
        .row_o   (pt_row),
        .col_o   (pt_col),
        .valid_o (pt_valid)
    );

    // A load request in the same cycle takes priority over an edit.
    assign edit_ready_o = rst_n_i && (state_q == ST_IDLE) && !load_req_i;
    assign edit_accept  = edit_valid_i && edit_ready_o;

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        row_d      = row_q;
        col_d      = col_q;
        case (state_q)
            ST_IDLE: begin
                if (load_req_i) begin
                    state_d    = ST_LOAD;
                    rom_addr_d = lvl_base(load_lvl_i);
                    row_d      = 4'd0;
                    col_d      = 5'd0;
                end
            end
            ST_LOAD: begin
                rom_addr_d = rom_addr_q + 1'b1;
                if (col_q == 5'(COL_MAX)) begin
                    if (row_q == 4'(ROW_MAX)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        col_d = 5'd0;
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            row_q      <= row_d;
            col_q      <= col_d;
        end
    end

    // The ROM answers one cycle after the address, so row/col follow one stage behind.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ld_vld_q <= 1'b0;
            ld_row_q <= '0;
            ld_col_q <= '0;
        end else begin
            ld_vld_q <= (state_q == ST_LOAD);
            ld_row_q <= row_q;
            ld_col_q <= col_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ed_vld_q  <= 1'b0;
            ed_err_q  <= 1'b0;
            ed_row_q  <= '0;
            ed_col_q  <= '0;
            ed_tile_q <= '0;
        end else begin
            ed_vld_q <= edit_accept && pt_valid;
            ed_err_q <= edit_accept && !pt_valid;
            if (edit_accept) begin
                ed_row_q  <= pt_row;
                ed_col_q  <= pt_col;
                ed_tile_q <= edit_tile_i;
            end
        end
    end

    // Edits are only accepted in IDLE, so an edit write can never coincide with a load write.
    always_comb begin
        wr_en_o   = 1'b0;
        wr_row_o  = '0;
        wr_col_o  = '0;
        wr_data_o = '0;
        if (ld_vld_q) begin
            wr_en_o   = 1'b1;
            wr_row_o  = ld_row_q;
            wr_col_o  = ld_col_q;
            wr_data_o = rom_data_i;
        end else if (ed_vld_q) begin
            wr_en_o   = 1'b1;
            wr_row_o  = ed_row_q;
            wr_col_o  = ed_col_q;
            wr_data_o = ed_tile_q;
        end
    end

    assign rom_addr_o  = rom_addr_q;
    assign edit_err_o  = ed_err_q;
    assign busy_o      = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign load_done_o = (state_q == ST_DONE);

endmodule
